// File: rtl/i2c_scl_timer_if.sv
// rtl/i2c_scl_timer_if.sv - control/status bundle between the I2C bit engine and the SCL timer
interface i2c_scl_timer_if #(
    parameter int DIV_WIDTH = 16
);
    logic                 enable;
    logic [DIV_WIDTH-1:0] div_quarter;
    logic                 stretch_en;
    logic                 scl_in;
    logic                 scl_out;
    logic                 tick_fall;
    logic                 tick_change;
    logic                 tick_rise;
    logic                 tick_sample;
    logic [1:0]           phase;
    logic                 busy;
    logic                 stretching;
    logic                 timeout_err;

    modport master (
        output enable, div_quarter, stretch_en, scl_in,
        input  scl_out, tick_fall, tick_change, tick_rise, tick_sample,
        input  phase, busy, stretching, timeout_err
    );

    modport slave (
        input  enable, div_quarter, stretch_en, scl_in,
        output scl_out, tick_fall, tick_change, tick_rise, tick_sample,
        output phase, busy, stretching, timeout_err
    );
endinterface

// File: rtl/i2c_scl_timer.sv
// rtl/i2c_scl_timer.sv - quarter-phase SCL timing generator with clock stretching and timeout
module i2c_scl_timer #(
    parameter int CLK_FREQ        = 50_000_000,
    parameter int I2C_FREQ        = 100_000,
    parameter int DIV_WIDTH       = 16,
    parameter int STRETCH_TIMEOUT = 50_000
) (
    input  logic           clk,
    input  logic           rst,
    i2c_scl_timer_if.slave bus
);
    localparam logic [DIV_WIDTH-1:0] Q0 = DIV_WIDTH'(CLK_FREQ / (4 * I2C_FREQ));
    localparam int SW = $clog2(STRETCH_TIMEOUT + 1);
    localparam logic [SW-1:0] STRETCH_LIMIT = SW'(STRETCH_TIMEOUT);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           phase_q, phase_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] qeff_q, qeff_d;
    logic [SW-1:0]        stretch_cnt_q, stretch_cnt_d;
    logic [3:0]           tick_q, tick_d;
    logic                 timeout_q, timeout_d;
    logic                 sync1_q, sync2_q;
    logic                 held;
    logic                 last;
    logic [DIV_WIDTH-1:0] qsel;

    // Slave holds the phase-2 count only while SCL is sensed low and stretching is honoured
    assign held = (state_q == S_RUN) && (phase_q == 2'd2) && bus.stretch_en && !sync2_q;
    assign last = (cnt_q == qeff_q - DIV_WIDTH'(1));
    assign qsel = (bus.div_quarter == '0) ? Q0 : bus.div_quarter;

    // Two-flop synchroniser for the open-drain SCL line; idles released
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.scl_in;
            sync2_q <= sync1_q;
        end
    end

    // State, counters and registered ticks
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            phase_q       <= 2'd3;
            cnt_q         <= '0;
            qeff_q        <= '0;
            stretch_cnt_q <= '0;
            tick_q        <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            cnt_q         <= cnt_d;
            qeff_q        <= qeff_d;
            stretch_cnt_q <= stretch_cnt_d;
            tick_q        <= tick_d;
            timeout_q     <= timeout_d;
        end
    end

    // Next-state: quarter counting, period restart or graceful stop, stretch hold and timeout
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        qeff_d        = qeff_q;
        stretch_cnt_d = stretch_cnt_q;
        tick_d        = '0;
        timeout_d     = timeout_q;
        case (state_q)
            S_IDLE: begin
                phase_d = 2'd3;
                cnt_d   = '0;
                if (bus.enable) begin
                    qeff_d    = qsel;
                    timeout_d = 1'b0;
                    state_d   = S_RUN;
                    phase_d   = 2'd0;
                    tick_d    = 4'b0001;
                end
            end
            S_RUN: begin
                if (held) begin
                    if (stretch_cnt_q == STRETCH_LIMIT) begin
                        timeout_d     = 1'b1;
                        state_d       = S_IDLE;
                        phase_d       = 2'd3;
                        cnt_d         = '0;
                        stretch_cnt_d = '0;
                    end else begin
                        stretch_cnt_d = stretch_cnt_q + SW'(1);
                    end
                end else if (last) begin
                    cnt_d = '0;
                    if (phase_q == 2'd3) begin
                        if (bus.enable) begin
                            qeff_d  = qsel;
                            phase_d = 2'd0;
                            tick_d  = 4'b0001;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                        tick_d  = 4'b0001 << phase_d;
                        if (phase_d == 2'd2) begin
                            stretch_cnt_d = '0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // SCL is released exactly in the two high quarters; idle reads phase 3 so SCL stays high
    assign bus.scl_out     = phase_q[1];
    assign bus.tick_fall   = tick_q[0];
    assign bus.tick_change = tick_q[1];
    assign bus.tick_rise   = tick_q[2];
    assign bus.tick_sample = tick_q[3];
    assign bus.phase       = phase_q;
    assign bus.busy        = (state_q == S_RUN);
    assign bus.stretching  = held;
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_i2c_scl_timer.sv
// tb/tb_i2c_scl_timer.sv - directed self-checking bench for i2c_scl_timer
module tb_i2c_scl_timer;
    logic clk = 1'b0;
    logic rst;
    int   nchk  = 0;
    int   npass = 0;

    always #5 clk = ~clk;

    i2c_scl_timer_if #(.DIV_WIDTH(16)) bus_a ();
    i2c_scl_timer_if #(.DIV_WIDTH(16)) bus_b ();

    i2c_scl_timer #(.STRETCH_TIMEOUT(50_000)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    i2c_scl_timer #(.STRETCH_TIMEOUT(10)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        assert (obs === exp) begin
            npass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ticks_a();
        return {28'd0, bus_a.tick_sample, bus_a.tick_rise, bus_a.tick_change, bus_a.tick_fall};
    endfunction

    function automatic int ticks_b();
        return {28'd0, bus_b.tick_sample, bus_b.tick_rise, bus_b.tick_change, bus_b.tick_fall};
    endfunction

    task automatic do_reset();
        rst               = 1'b1;
        bus_a.enable      = 1'b0;
        bus_a.div_quarter = 16'd0;
        bus_a.stretch_en  = 1'b0;
        bus_a.scl_in      = 1'b1;
        bus_b.enable      = 1'b0;
        bus_b.div_quarter = 16'd0;
        bus_b.stretch_en  = 1'b0;
        bus_b.scl_in      = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int exp_t;
        int exp_s;
        int f1;
        int f2;
        int ch1;

        // Reset state
        do_reset();
        chk("reset scl_out", int'(bus_a.scl_out), 1);
        chk("reset phase", int'(bus_a.phase), 3);
        chk("reset busy", int'(bus_a.busy), 0);
        chk("reset ticks", ticks_a(), 0);
        chk("reset stretching", int'(bus_a.stretching), 0);
        chk("reset timeout_err", int'(bus_a.timeout_err), 0);

        // Basic timing, Q = 3
        bus_a.div_quarter = 16'd3;
        bus_a.enable      = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            step();
            exp_t = (c == 1 || c == 13) ? 1 : (c == 4) ? 2 : (c == 7) ? 4 : (c == 10) ? 8 : 0;
            exp_s = (c >= 7 && c <= 12) ? 1 : 0;
            chk($sformatf("basic c%0d ticks", c), ticks_a(), exp_t);
            chk($sformatf("basic c%0d scl_out", c), int'(bus_a.scl_out), exp_s);
        end
        chk("basic c13 phase", int'(bus_a.phase), 0);
        chk("basic c13 busy", int'(bus_a.busy), 1);

        // Graceful stop: enable dropped at cycle 5
        do_reset();
        bus_a.div_quarter = 16'd3;
        bus_a.enable      = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 5) bus_a.enable = 1'b0;
            if (c == 12) chk("stop c12 busy", int'(bus_a.busy), 1);
            if (c == 13 || c == 14) begin
                chk($sformatf("stop c%0d busy", c), int'(bus_a.busy), 0);
                chk($sformatf("stop c%0d scl_out", c), int'(bus_a.scl_out), 1);
                chk($sformatf("stop c%0d phase", c), int'(bus_a.phase), 3);
                chk($sformatf("stop c%0d ticks", c), ticks_a(), 0);
            end
        end

        // Rate change: div_quarter 3 -> 2 at cycle 8 takes effect at the period boundary
        do_reset();
        bus_a.div_quarter = 16'd3;
        bus_a.enable      = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            step();
            if (c == 8) bus_a.div_quarter = 16'd2;
            if (c >= 9) begin
                exp_t = (c == 10) ? 8 : (c == 13) ? 1 : (c == 15) ? 2 : (c == 17) ? 4 : 0;
                chk($sformatf("rate c%0d ticks", c), ticks_a(), exp_t);
            end
        end

        // Qeff = 1: ticks on consecutive cycles
        do_reset();
        bus_a.div_quarter = 16'd1;
        bus_a.enable      = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            exp_t = (c == 1 || c == 5) ? 1 : (c == 2) ? 2 : (c == 3) ? 4 : 8;
            chk($sformatf("q1 c%0d ticks", c), ticks_a(), exp_t);
        end

        // Default divisor: 500-cycle period, tick_change 125 after tick_fall
        do_reset();
        bus_a.div_quarter = 16'd0;
        bus_a.enable      = 1'b1;
        f1  = -1;
        f2  = -1;
        ch1 = -1;
        for (int c = 1; c <= 1100; c++) begin
            step();
            if (bus_a.tick_fall) begin
                if (f1 < 0) f1 = c;
                else if (f2 < 0) f2 = c;
            end
            if (bus_a.tick_change && ch1 < 0) ch1 = c;
        end
        chk("default first tick_fall", f1, 1);
        chk("default fall spacing", f2 - f1, 500);
        chk("default change offset", ch1 - f1, 125);

        // Stretching: scl_in low during cycles 5..19, released at 20
        do_reset();
        bus_a.div_quarter = 16'd3;
        bus_a.stretch_en  = 1'b1;
        bus_a.enable      = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            step();
            if (c == 5) bus_a.scl_in = 1'b0;
            if (c == 20) bus_a.scl_in = 1'b1;
            exp_t = (c == 1 || c == 28) ? 1 : (c == 4) ? 2 : (c == 7) ? 4 : (c == 25) ? 8 : 0;
            exp_s = (c >= 7 && c <= 21) ? 1 : 0;
            chk($sformatf("stretch c%0d ticks", c), ticks_a(), exp_t);
            chk($sformatf("stretch c%0d stretching", c), int'(bus_a.stretching), exp_s);
            if (c >= 7 && c <= 27)
                chk($sformatf("stretch c%0d scl_out", c), int'(bus_a.scl_out), 1);
        end

        // Timeout on the STRETCH_TIMEOUT = 10 instance, scl_in stuck low
        do_reset();
        bus_b.div_quarter = 16'd3;
        bus_b.stretch_en  = 1'b1;
        bus_b.enable      = 1'b1;
        bus_b.scl_in      = 1'b0;
        for (int c = 1; c <= 21; c++) begin
            step();
            if (c == 7) chk("tmo c7 ticks", ticks_b(), 4);
            if (c == 17) begin
                chk("tmo c17 busy", int'(bus_b.busy), 1);
                chk("tmo c17 timeout_err", int'(bus_b.timeout_err), 0);
                chk("tmo c17 stretching", int'(bus_b.stretching), 1);
            end
            if (c == 18) begin
                chk("tmo c18 timeout_err", int'(bus_b.timeout_err), 1);
                chk("tmo c18 busy", int'(bus_b.busy), 0);
                chk("tmo c18 scl_out", int'(bus_b.scl_out), 1);
                chk("tmo c18 phase", int'(bus_b.phase), 3);
                chk("tmo c18 ticks", ticks_b(), 0);
                chk("tmo c18 stretching", int'(bus_b.stretching), 0);
            end
            if (c == 20) begin
                chk("tmo c20 sticky", int'(bus_b.timeout_err), 1);
                chk("tmo c20 busy", int'(bus_b.busy), 0);
            end
            if (c == 21) begin
                chk("tmo c21 restart clears", int'(bus_b.timeout_err), 0);
                chk("tmo c21 busy", int'(bus_b.busy), 1);
                chk("tmo c21 ticks", ticks_b(), 1);
            end
            if (c == 10) bus_b.enable = 1'b0;
            if (c == 20) begin
                bus_b.enable = 1'b1;
                bus_b.scl_in = 1'b1;
            end
        end

        // Reset during phase 1
        do_reset();
        bus_a.div_quarter = 16'd3;
        bus_a.enable      = 1'b1;
        for (int c = 1; c <= 5; c++) step();
        chk("midrst c5 phase", int'(bus_a.phase), 1);
        rst = 1'b1;
        step();
        chk("midrst scl_out", int'(bus_a.scl_out), 1);
        chk("midrst phase", int'(bus_a.phase), 3);
        chk("midrst busy", int'(bus_a.busy), 0);
        chk("midrst ticks", ticks_a(), 0);
        chk("midrst timeout_err", int'(bus_a.timeout_err), 0);
        rst          = 1'b0;
        bus_a.enable = 1'b0;
        step();

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
